// File: rtl/register_write_buffer.sv
// Queues register-file write requests and drains them one per cycle to the write port.
// Latency: accepted at edge N, committed on WriteEnable during cycle N+1 -> N+2 (no stall).
// Backpressure: ReqReady drops when the FIFO is full; WriteStall holds the queue without loss.
module register_write_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ReqValid,
   output logic                      ReqReady,
   input  logic [ADDR_WIDTH-1:0]     ReqAddress,
   input  logic [DATA_WIDTH-1:0]     ReqValue,
   input  logic                      WriteStall,
   output logic                      WriteEnable,
   output logic [ADDR_WIDTH-1:0]     WriteAddress,
   output logic [DATA_WIDTH-1:0]     WriteValue,
   input  logic [ADDR_WIDTH-1:0]     ProbeAddress,
   output logic                      ProbeHit,
   output logic [DATA_WIDTH-1:0]     ProbeValue,
   output logic [$clog2(DEPTH):0]    PendingCount,
   output logic                      Empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      count;
   logic [PTR_W-1:0]      probe_idx;
   logic                  push;
   logic                  pop;

   // Ready depends on occupancy only, so a full buffer refuses a push even while popping.
   assign ReqReady     = (count != CNT_W'(DEPTH));
   assign push         = ReqValid && ReqReady && !reset;
   assign pop          = (count != '0) && !WriteStall;
   assign PendingCount = count;
   assign Empty        = (count == '0) && !WriteEnable;

   // Entry storage: written at the tail on an accepted request; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= ReqAddress;
         data_mem[tail] <= ReqValue;
      end
   end

   // Pointers, occupancy and the registered write-port stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         WriteEnable  <= 1'b0;
         WriteAddress <= '0;
         WriteValue   <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head         <= head + 1'b1;
            WriteEnable  <= 1'b1;
            WriteAddress <= addr_mem[head];
            WriteValue   <= data_mem[head];
         end else begin
            WriteEnable  <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Forwarding probe: scan oldest to youngest so the youngest matching entry wins;
   // the output stage is the oldest candidate of all.
   always_comb begin
      ProbeHit   = 1'b0;
      ProbeValue = '0;
      probe_idx  = head;
      if (WriteEnable && (WriteAddress == ProbeAddress)) begin
         ProbeHit   = 1'b1;
         ProbeValue = WriteValue;
      end
      for (int i = 0; i < DEPTH; i++) begin
         probe_idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (addr_mem[probe_idx] == ProbeAddress)) begin
            ProbeHit   = 1'b1;
            ProbeValue = data_mem[probe_idx];
         end
      end
   end

endmodule

// File: tb/tb_register_write_buffer.sv
// Directed bench for register_write_buffer: reset, single write, fill/backpressure,
// forwarding priority, output-stage probe, wrap-around streaming and mid-operation reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_register_write_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ReqValid;
   logic        ReqReady;
   logic [4:0]  ReqAddress;
   logic [15:0] ReqValue;
   logic        WriteStall;
   logic        WriteEnable;
   logic [4:0]  WriteAddress;
   logic [15:0] WriteValue;
   logic [4:0]  ProbeAddress;
   logic        ProbeHit;
   logic [15:0] ProbeValue;
   logic [2:0]  PendingCount;
   logic        Empty;

   int compared = 0;
   int mismatched = 0;

   register_write_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ReqAddress   (ReqAddress),
      .ReqValue     (ReqValue),
      .WriteStall   (WriteStall),
      .WriteEnable  (WriteEnable),
      .WriteAddress (WriteAddress),
      .WriteValue   (WriteValue),
      .ProbeAddress (ProbeAddress),
      .ProbeHit     (ProbeHit),
      .ProbeValue   (ProbeValue),
      .PendingCount (PendingCount),
      .Empty        (Empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [4:0] a, input logic [15:0] v);
      ReqValid   = 1'b1;
      ReqAddress = a;
      ReqValue   = v;
   endtask

   task automatic probe(input string tag, input logic [4:0] a, input logic hit, input logic [15:0] v);
      ProbeAddress = a;
      #1;
      chk({tag, "_hit"}, 32'(ProbeHit), 32'(hit));
      chk({tag, "_val"}, 32'(ProbeValue), 32'(v));
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [15:0] v);
      chk({tag, "_we"}, 32'(WriteEnable), 32'(en));
      chk({tag, "_wa"}, 32'(WriteAddress), 32'(a));
      chk({tag, "_wv"}, 32'(WriteValue), 32'(v));
   endtask

   initial begin
      reset = 1'b1; ReqValid = 1'b0; ReqAddress = '0; ReqValue = '0;
      WriteStall = 1'b0; ProbeAddress = '0;
      step(); step();
      reset = 1'b0;

      // Reset values
      chk("rst_ready", 32'(ReqReady), 32'd1);
      chk_wr("rst", 1'b0, 5'd0, 16'h0000);
      chk("rst_count", 32'(PendingCount), 32'd0);
      chk("rst_empty", 32'(Empty), 32'd1);
      probe("rst_probe", 5'd0, 1'b0, 16'h0000);

      // Single write: accepted at edge 1, on the port during cycle 2->3 only
      push_req(5'd3, 16'h00AA);
      step();
      ReqValid = 1'b0;
      chk("sw_count1", 32'(PendingCount), 32'd1);
      chk("sw_we_early", 32'(WriteEnable), 32'd0);
      chk("sw_empty0", 32'(Empty), 32'd0);
      probe("sw_probe_fifo", 5'd3, 1'b1, 16'h00AA);
      step();
      chk_wr("sw_commit", 1'b1, 5'd3, 16'h00AA);
      chk("sw_count0", 32'(PendingCount), 32'd0);
      step();
      chk_wr("sw_after", 1'b0, 5'd3, 16'h00AA);
      chk("sw_empty1", 32'(Empty), 32'd1);

      // Fill under stall, then drain in order
      WriteStall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         push_req(5'(i), 16'h0100 + 16'(i));
         step();
      end
      chk("fill_count4", 32'(PendingCount), 32'd4);
      chk("fill_ready0", 32'(ReqReady), 32'd0);
      push_req(5'd9, 16'h0999);
      step();
      ReqValid = 1'b0;
      chk("fill_refused_count", 32'(PendingCount), 32'd4);
      chk("fill_stall_we", 32'(WriteEnable), 32'd0);
      probe("fill_probe9", 5'd9, 1'b0, 16'h0000);
      probe("fill_probe2", 5'd2, 1'b1, 16'h0102);
      WriteStall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_wr($sformatf("drain%0d", i), 1'b1, 5'(i), 16'h0100 + 16'(i));
         chk($sformatf("drain%0d_count", i), 32'(PendingCount), 32'(4 - i));
      end
      step();
      chk_wr("drain_done", 1'b0, 5'd4, 16'h0104);
      chk("drain_empty", 32'(Empty), 32'd1);

      // Forwarding priority: youngest entry for an address wins
      WriteStall = 1'b1;
      push_req(5'd7, 16'h1111); step();
      push_req(5'd7, 16'h2222); step();
      ReqValid = 1'b0;
      probe("fwd_probe7", 5'd7, 1'b1, 16'h2222);
      probe("fwd_probe8", 5'd8, 1'b0, 16'h0000);
      WriteStall = 1'b0;
      step();
      chk_wr("fwd_commit1", 1'b1, 5'd7, 16'h1111);
      probe("fwd_probe7_mix", 5'd7, 1'b1, 16'h2222);
      step();
      chk_wr("fwd_commit2", 1'b1, 5'd7, 16'h2222);
      probe("fwd_probe7_out", 5'd7, 1'b1, 16'h2222);
      step();
      chk("fwd_we_off", 32'(WriteEnable), 32'd0);
      probe("fwd_probe7_gone", 5'd7, 1'b0, 16'h0000);

      // Output-stage probe with the FIFO empty
      push_req(5'd5, 16'h0055); step();
      ReqValid = 1'b0;
      step();
      chk("os_count0", 32'(PendingCount), 32'd0);
      chk("os_we", 32'(WriteEnable), 32'd1);
      probe("os_probe5", 5'd5, 1'b1, 16'h0055);
      step();

      // Wrap-around: ten back-to-back writes, one commit per cycle
      for (int i = 0; i < 10; i++) begin
         push_req(5'(i), 16'h1000 + 16'(i));
         step();
         chk($sformatf("wrap%0d_cnt_le1", i), 32'(PendingCount <= 3'd1), 32'd1);
         if (i >= 1) chk_wr($sformatf("wrap%0d", i), 1'b1, 5'(i - 1), 16'h1000 + 16'(i - 1));
      end
      ReqValid = 1'b0;
      step();
      chk_wr("wrap_last", 1'b1, 5'd9, 16'h1009);
      chk("wrap_count0", 32'(PendingCount), 32'd0);
      step();
      chk("wrap_we_off", 32'(WriteEnable), 32'd0);

      // Reset mid-operation discards pending writes and refuses requests during reset
      WriteStall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_req(5'(20 + i), 16'hBEE0 + 16'(i));
         step();
      end
      chk("mr_count3", 32'(PendingCount), 32'd3);
      push_req(5'd23, 16'hDEAD);
      reset = 1'b1;
      step();
      reset = 1'b0; ReqValid = 1'b0; WriteStall = 1'b0;
      chk("mr_count0", 32'(PendingCount), 32'd0);
      chk_wr("mr_port", 1'b0, 5'd0, 16'h0000);
      chk("mr_empty", 32'(Empty), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("mr_quiet%0d", i), 32'(WriteEnable), 32'd0);
      end
      chk("mr_count_end", 32'(PendingCount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
